// File: rtl/vend_sequencer.sv
// vend_sequencer: transaction controller for the vending datapath.
// It adds up coin credit, checks a product selection against the slot
// price table, then runs the dispense motor and the change hopper one
// at a time through req/ack handshakes.
//
// Ports:
//   clk, reset        system clock (rising edge), async active-high reset
//   coin[2:0]         coin value inserted this cycle (0 = none)
//   cancel            refund request
//   sel_valid, sel_id product selection strobe and slot
//   motor_ack         motor driver finished a dispense
//   chg_ack           hopper finished one payout
//   balance[3:0]      current credit
//   motor_req, motor_id[1:0]  dispense request and slot
//   chg_req, chg_val[1:0]     payout request and denomination (1 or 2)
//   dispense, coin_reject, sel_reject, fault  single-cycle event pulses
//
// state   | meaning
// COLLECT | accepting coins, cancel and selections
// VEND    | motor_req held, waiting for motor_ack or timeout
// CHANGE  | paying out the remaining balance through the hopper
module vend_sequencer #(
  parameter int PRICE0  = 7,
  parameter int PRICE1  = 5,
  parameter int PRICE2  = 9,
  parameter int PRICE3  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] coin,
  input  logic       cancel,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       motor_ack,
  input  logic       chg_ack,
  output logic [3:0] balance,
  output logic       motor_req,
  output logic [1:0] motor_id,
  output logic       chg_req,
  output logic [1:0] chg_val,
  output logic       dispense,
  output logic       coin_reject,
  output logic       sel_reject,
  output logic       fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  state_t      state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]  balance_nx;
  logic        motor_req_nx, chg_req_nx;
  logic [1:0]  motor_id_nx, chg_val_nx;
  logic        dispense_nx, coin_reject_nx, sel_reject_nx, fault_nx;

  logic [4:0]  coin_sum;
  logic [3:0]  vend_rest;
  logic [3:0]  paid_rest;

  function automatic logic [3:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    return 4'(PRICE0);
      2'd1:    return 4'(PRICE1);
      2'd2:    return 4'(PRICE2);
      default: return 4'(PRICE3);
    endcase
  endfunction

  function automatic logic [1:0] denom(input logic [3:0] b);
    return (b >= 4'd2) ? 2'd2 : 2'd1;
  endfunction

  // 5-bit sum so an overflowing coin is detected before it can wrap
  assign coin_sum  = {1'b0, balance} + {2'b00, coin};
  // a vend is only started when price <= balance, so these cannot underflow
  assign vend_rest = balance - price_of(motor_id);
  assign paid_rest = balance - {2'b00, chg_val};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= COLLECT;
      cnt         <= '0;
      balance     <= '0;
      motor_req   <= 1'b0;
      motor_id    <= '0;
      chg_req     <= 1'b0;
      chg_val     <= '0;
      dispense    <= 1'b0;
      coin_reject <= 1'b0;
      sel_reject  <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      balance     <= balance_nx;
      motor_req   <= motor_req_nx;
      motor_id    <= motor_id_nx;
      chg_req     <= chg_req_nx;
      chg_val     <= chg_val_nx;
      dispense    <= dispense_nx;
      coin_reject <= coin_reject_nx;
      sel_reject  <= sel_reject_nx;
      fault       <= fault_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    balance_nx     = balance;
    motor_req_nx   = motor_req;
    motor_id_nx    = motor_id;
    chg_req_nx     = chg_req;
    chg_val_nx     = chg_val;
    dispense_nx    = 1'b0;
    coin_reject_nx = 1'b0;
    sel_reject_nx  = 1'b0;
    fault_nx       = 1'b0;

    case (state)
      COLLECT: begin
        if (cancel && balance != 4'd0) begin
          // refund wins; a coin arriving with it is handed back
          coin_reject_nx = (coin != 3'd0);
          chg_req_nx     = 1'b1;
          chg_val_nx     = denom(balance);
          state_nx       = CHANGE;
        end else begin
          if (coin != 3'd0) begin
            if (coin_sum <= 5'd15) balance_nx = coin_sum[3:0];
            else                   coin_reject_nx = 1'b1;
          end
          // price is compared against the credit before this cycle's coin
          if (sel_valid) begin
            if (price_of(sel_id) <= balance) begin
              motor_id_nx  = sel_id;
              motor_req_nx = 1'b1;
              cnt_nx       = '0;
              state_nx     = VEND;
            end else begin
              sel_reject_nx = 1'b1;
            end
          end
        end
      end

      VEND: begin
        coin_reject_nx = (coin != 3'd0);
        if (motor_ack) begin
          balance_nx   = vend_rest;
          dispense_nx  = 1'b1;
          motor_req_nx = 1'b0;
          cnt_nx       = '0;
          if (vend_rest != 4'd0) begin
            chg_req_nx = 1'b1;
            chg_val_nx = denom(vend_rest);
            state_nx   = CHANGE;
          end else begin
            state_nx   = COLLECT;
          end
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // give up on the motor and refund the full credit
          motor_req_nx = 1'b0;
          fault_nx     = 1'b1;
          cnt_nx       = '0;
          chg_req_nx   = 1'b1;
          chg_val_nx   = denom(balance);
          state_nx     = CHANGE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      CHANGE: begin
        coin_reject_nx = (coin != 3'd0);
        if (chg_req) begin
          if (chg_ack) begin
            balance_nx = paid_rest;
            chg_req_nx = 1'b0;
            if (paid_rest == 4'd0) state_nx = COLLECT;
          end
        end else if (balance == 4'd0) begin
          state_nx = COLLECT;
        end else begin
          // one idle cycle between payouts, then the next denomination
          chg_req_nx = 1'b1;
          chg_val_nx = denom(balance);
        end
      end

      default: state_nx = COLLECT;
    endcase
  end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Top-level transaction controller for the vending datapath: accumulates coin credit, arbitrates product selection against a per-slot price table, and sequences the shared dispense motor and change-payout hopper through req/ack handshakes.
- Sits between the coin/keypad front end and the motor and hopper drivers.
- Only one of the motor and the hopper is active at any time.

Parameters:
PRICE0, 7, price of slot 0 in coin units (legal range 1..15)
PRICE1, 5, price of slot 1 (1..15)
PRICE2, 9, price of slot 2 (1..15)
PRICE3, 12, price of slot 3 (1..15)
TIMEOUT, 16, maximum cycles motor_req is held without motor_ack before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
coin  in  3  coin value inserted this cycle in units; 0 = no coin
cancel  in  1  refund request, level sampled each cycle
sel_valid  in  1  product selection strobe
sel_id  in  2  selected slot, valid with sel_valid
motor_ack  in  1  motor driver completed dispense
chg_ack  in  1  hopper completed one payout
balance  out  4  current credit in units
motor_req  out  1  dispense request, held until ack or timeout
motor_id  out  2  slot to dispense, stable while motor_req=1
chg_req  out  1  change payout request, held until chg_ack
chg_val  out  2  payout denomination (1 or 2), stable while chg_req=1
dispense  out  1  1-cycle pulse on successful vend
coin_reject  out  1  1-cycle pulse, coin not credited
sel_reject  out  1  1-cycle pulse, selection refused
fault  out  1  1-cycle pulse on motor timeout

Behaviour:
- Reset: all outputs 0, state COLLECT, timeout counter 0. An asserted reset mid-transaction drops motor_req/chg_req immediately and forfeits the credit (balance=0).
- All outputs are registered. A response appears the cycle after the causing input edge.
- States: COLLECT, VEND, CHANGE.
- COLLECT, coin handling:
  - coin!=0 and balance+coin<=15: balance += coin (5-bit sum checked before the update).
  - Sum >15: balance unchanged, coin_reject pulses.
- COLLECT, priority order (highest first):
  - cancel: if balance>0, go CHANGE; a coin in the same cycle is rejected (coin_reject). If balance==0, no action.
  - sel_valid with PRICE[sel_id] <= current balance (pre-coin value): latch motor_id=sel_id, go VEND. A same-cycle coin is still credited by the coin rule.
  - sel_valid with price > balance: sel_reject pulses, stay in COLLECT.
- VEND:
  - motor_req=1 from the first cycle in VEND; timeout counter increments each cycle.
  - On motor_ack: balance -= price, dispense pulses, motor_req deasserts next cycle. Go CHANGE if remainder>0, else COLLECT.
  - Counter reaching TIMEOUT without ack: motor_req deasserts, fault pulses, balance is kept intact (full refund), go CHANGE.
  - motor_ack outside VEND is ignored.
- CHANGE:
  - chg_req=1; chg_val=2 if balance>=2, else 1.
  - On chg_ack: balance -= chg_val. chg_req drops for exactly one cycle, then reasserts with the new chg_val if balance>0. If balance==0, go COLLECT.
  - chg_ack is ignored when chg_req=0.
- In VEND and CHANGE: every nonzero coin gives coin_reject; cancel and sel_valid are ignored, with no sel_reject.
- motor_req and chg_req are never high simultaneously.
- balance never wraps or underflows.

Test Plan:
- Reset, coins 2,2,3, sel_valid sel_id=0 (price 7), motor_ack after 3 cycles -> motor_req for 3 cycles with motor_id=0, dispense pulse, balance 7->0, return to COLLECT, no chg_req.
- Coins 5,5, select slot 1 (price 5), ack -> balance 5. CHANGE issues chg_val=2, ack, chg_val=2, ack, chg_val=1, ack -> balance 0, COLLECT.
- balance=13, coin=3 -> coin_reject pulse, balance stays 13. Then coin=2 -> balance 15.
- balance=4, select slot 2 (price 9) -> sel_reject, balance 4, no motor_req. Then cancel -> chg_val 2,2 paid, balance 0.
- balance=12, select slot 3, never ack -> motor_req high for TIMEOUT=16 cycles, fault pulse, CHANGE refunds 12 as six chg_val=2 payouts.
- Assert reset while chg_req=1 mid-refund -> chg_req and balance go 0 asynchronously. After release: COLLECT, coin=5 credited.
